// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready,
// executed against a little-endian doubleword array after wait states.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] WC = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
  } req_t;

  state_t      state, state_n;
  req_t        req_q, in_req, cur;
  logic [7:0]  cnt;
  logic        rdy_q;
  logic        rv_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem [DEPTH];

  logic        acc;
  logic        go_resp;
  logic [2:0]  lane;
  logic [IW-1:0] idx;
  logic        oor;
  logic        mis;
  logic        bad;
  logic [7:0]  bmask;
  logic [63:0] rd_word;
  logic [63:0] wsh;
  logic [63:0] rsh;
  logic [63:0] st_word;
  logic [63:0] ld_ext;

  assign in_req = '{
    write: req_write,
    addr:  req_addr,
    size:  req_size,
    uns:   req_unsigned,
    wdata: req_wdata
  };

  assign acc        = req_valid & rdy_q;
  assign req_ready  = rdy_q;
  assign resp_valid = rv_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_n = state;
    go_resp = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (acc) begin
          if (WC == 8'd0) begin
            state_n = S_RESP;
            go_resp = 1'b1;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 8'd0) begin
          state_n = S_RESP;
          go_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Zero wait states access the live request in the accept cycle
  always_comb begin
    cur     = (state == S_IDLE) ? in_req : req_q;
    lane    = cur.addr[2:0];
    idx     = cur.addr[IW+2:3];
    oor     = cur.addr[63:3] >= 61'(DEPTH);
    mis     = 1'b0;
    bmask   = 8'h00;
    unique case (cur.size)
      2'd0: bmask = 8'h01;
      2'd1: begin
        mis   = cur.addr[0];
        bmask = 8'h03;
      end
      2'd2: begin
        mis   = |cur.addr[1:0];
        bmask = 8'h0f;
      end
      default: begin
        mis   = |cur.addr[2:0];
        bmask = 8'hff;
      end
    endcase
    bad     = mis | oor;
    bmask   = bmask << lane;
    rd_word = oor ? 64'd0 : mem[idx];
    wsh     = cur.wdata << {lane, 3'b000};
    rsh     = rd_word >> {lane, 3'b000};
    st_word = rd_word;
    for (int i = 0; i < 8; i++) begin
      if (bmask[i]) st_word[i*8 +: 8] = wsh[i*8 +: 8];
    end
    ld_ext = rsh;
    unique case (cur.size)
      2'd0: ld_ext = cur.uns ? {56'd0, rsh[7:0]}
                             : {{56{rsh[7]}}, rsh[7:0]};
      2'd1: ld_ext = cur.uns ? {48'd0, rsh[15:0]}
                             : {{48{rsh[15]}}, rsh[15:0]};
      2'd2: ld_ext = cur.uns ? {32'd0, rsh[31:0]}
                             : {{32{rsh[31]}}, rsh[31:0]};
      default: ld_ext = rsh;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      rdy_q   <= 1'b0;
      cnt     <= 8'd0;
      req_q   <= '0;
      rv_q    <= 1'b0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      rdy_q <= (state_n == S_IDLE);
      if (acc) begin
        req_q <= in_req;
        cnt   <= WC;
      end else if (state == S_WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (go_resp) begin
        rv_q    <= 1'b1;
        err_q   <= bad;
        rdata_q <= (bad | cur.write) ? 64'd0 : ld_ext;
      end else if (state == S_RESP && resp_ready) begin
        rv_q    <= 1'b0;
        rdata_q <= 64'd0;
        err_q   <= 1'b0;
      end
    end
  end

  // Array is not reset; writes gate on FSM state, which is
  always_ff @(posedge clk) begin
    if (go_resp && cur.write && !bad) mem[idx] <= st_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed cases plus random traffic
// against a byte-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 16;
  localparam int WC    = 2;
  localparam int NB    = DEPTH * 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mm [NB];

  data_mem_responder #(
    .DEPTH(DEPTH),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ref_bad(input logic [63:0] a,
                                   input logic [1:0] s);
    longint unsigned n = 64'd1 << s;
    return ((a % n) != 0) || ((a >> 3) >= 64'(DEPTH));
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a,
                                           input logic [1:0] s,
                                           input logic u);
    logic [63:0] v = 64'd0;
    logic [63:0] ones = '1;
    int n = 1 << s;
    for (int i = 0; i < n; i++)
      v |= 64'(mm[int'(a) + i]) << (8 * i);
    if (!u && n < 8 && v[8*n-1]) v |= ones << (8 * n);
    return v;
  endfunction

  function automatic void ref_store(input logic [63:0] a,
                                    input logic [1:0] s,
                                    input logic [63:0] d);
    int n = 1 << s;
    for (int i = 0; i < n; i++)
      mm[int'(a) + i] = d[8*i +: 8];
  endfunction

  task automatic drive(input logic wr, input logic [63:0] a,
                       input logic [1:0] s, input logic u,
                       input logic [63:0] wd);
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = a;
    req_size     = s;
    req_unsigned = u;
    req_wdata    = wd;
  endtask

  // Accept at a posedge; returns #1 after the accept edge
  task automatic accept(input logic wr, input logic [63:0] a,
                        input logic [1:0] s, input logic u,
                        input logic [63:0] wd);
    int t = 0;
    @(negedge clk);
    drive(wr, a, s, u, wd);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) chk("accept_timeout", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic xact(input logic wr, input logic [63:0] a,
                      input logic [1:0] s, input logic u,
                      input logic [63:0] wd, input int stall,
                      input logic poke, output logic [63:0] rd);
    logic        e_err;
    logic [63:0] e_rd;
    int          lat;
    e_err = ref_bad(a, s);
    e_rd  = (e_err || wr) ? 64'd0 : ref_load(a, s, u);
    accept(wr, a, s, u, wd);
    if (wr && !e_err) ref_store(a, s, wd);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid && lat < 50);
    chk("latency", 64'(lat), 64'(WC + 1));
    chk("rdata", resp_rdata, e_rd);
    chk("err", {63'd0, resp_err}, {63'd0, e_err});
    rd = resp_rdata;
    for (int i = 0; i < stall; i++) begin
      if (poke) drive(1'b1, 64'h8, 2'd3, 1'b0, 64'hbad);
      @(posedge clk);
      #1;
      chk("stall_rv", {63'd0, resp_valid}, 64'd1);
      chk("stall_rdata", resp_rdata, e_rd);
      chk("stall_err", {63'd0, resp_err}, {63'd0, e_err});
      chk("stall_rdy", {63'd0, req_ready}, 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("post_rv", {63'd0, resp_valid}, 64'd0);
    chk("post_rdata", resp_rdata, 64'd0);
    chk("post_rdy", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] rd;
    logic [1:0]  s;
    logic [63:0] a;
    int          k;
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = 64'd0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 64'd0;
    resp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", {63'd0, req_ready}, 64'd0);
    chk("rst_rv", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_rdy", {63'd0, req_ready}, 64'd1);
    chk("rel_rv", {63'd0, resp_valid}, 64'd0);
    chk("rel_rdata", resp_rdata, 64'd0);
    chk("rel_err", {63'd0, resp_err}, 64'd0);

    for (int w = 0; w < DEPTH; w++)
      xact(1'b1, 64'(w * 8), 2'd3, 1'b0, 64'd0, 0, 1'b0, rd);

    xact(1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788, 0, 1'b0, rd);
    xact(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 0, 1'b0, rd);
    chk("ld_dw", rd, 64'h1122334455667788);
    xact(1'b1, 64'h13, 2'd0, 1'b0, 64'hff, 0, 1'b0, rd);
    xact(1'b0, 64'h13, 2'd0, 1'b0, 64'd0, 0, 1'b0, rd);
    chk("ld_b_s", rd, 64'hffffffffffffffff);
    xact(1'b0, 64'h13, 2'd0, 1'b1, 64'd0, 0, 1'b0, rd);
    chk("ld_b_u", rd, 64'h00000000000000ff);
    xact(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 0, 1'b0, rd);
    chk("ld_dw_mix", rd, 64'h11223344ff667788);
    xact(1'b0, 64'h11, 2'd1, 1'b0, 64'd0, 0, 1'b0, rd);
    xact(1'b1, 64'(NB), 2'd3, 1'b0, 64'hdeadbeefcafef00d, 0, 1'b0, rd);
    for (int w = 0; w < DEPTH; w++)
      xact(1'b0, 64'(w * 8), 2'd3, 1'b0, 64'd0, 0, 1'b0, rd);
    xact(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 5, 1'b1, rd);

    // Reset while waiting: store must be lost
    accept(1'b1, 64'h20, 2'd0, 1'b0, 64'hab);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_rdy", {63'd0, req_ready}, 64'd0);
    chk("rw_rv", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rw_idle", {63'd0, req_ready}, 64'd1);
    xact(1'b0, 64'h20, 2'd0, 1'b1, 64'd0, 0, 1'b0, rd);
    chk("rw_old", rd, 64'd0);

    // Reset while responding: store already committed
    accept(1'b1, 64'h28, 2'd0, 1'b0, 64'hcd);
    ref_store(64'h28, 2'd0, 64'hcd);
    k = 0;
    while (!resp_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rr_rv", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    xact(1'b0, 64'h28, 2'd0, 1'b1, 64'd0, 0, 1'b0, rd);
    chk("rr_new", rd, 64'hcd);

    for (int n = 0; n < 300; n++) begin
      s = 2'($urandom_range(0, 3));
      k = $urandom_range(0, 9);
      if (k < 7)
        a = 64'($urandom_range(0, NB - 1)) & ~((64'd1 << s) - 1);
      else if (k < 9)
        a = 64'($urandom_range(0, NB - 1));
      else
        a = {$urandom, $urandom} | 64'(NB);
      xact(1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)),
           {$urandom, $urandom}, $urandom_range(0, 3), 1'b0, rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
